burst_read_sched: RTL and testbench

Sequences a frame-sized read through the Avalon burst read engine, which has a start/busy control port. Splits a region of cfg_length words at cfg_base into bursts of BURST_COUNT words, with a shorter tail burst. Issues a burst only when the downstream FIFO reports enough free space for the whole burst. Supports single-shot and continuous (frame-looping) modes, abort, and beat-count checking; sits between the CPU-side configuration registers and the burst read engine.

---
 rtl/burst_read_sched_pkg.sv | 17 +
 rtl/burst_read_sched.sv | 258 +++++++++++++++++++++++++
 tb/tb_burst_read_sched.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_read_sched_pkg.sv
// Shared definitions for the burst read scheduler: one-hot state encoding
// and default geometry of a burst.
package burst_read_sched_pkg;

    typedef enum logic [5:0] {
        ST_IDLE      = 6'b000001,
        ST_CHECK     = 6'b000010,
        ST_ISSUE     = 6'b000100,
        ST_WAIT_ACK  = 6'b001000,
        ST_WAIT_DONE = 6'b010000,
        ST_FINISH    = 6'b100000
    } state_t;

    localparam int DEF_BURST_COUNT    = 8;
    localparam int DEF_BYTES_PER_WORD = 4;

endpackage

// File: rtl/burst_read_sched.sv
// Burst read scheduler: walks a frame of cfg_length words starting at
// cfg_base, handing the burst read engine one burst at a time (at most
// BURST_COUNT words) once the downstream FIFO can absorb the whole burst.
// Supports frame looping, abort (never cancels an issued burst) and a
// sticky beat-count mismatch flag.
module burst_read_sched
    import burst_read_sched_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int LENGTH_WIDTH   = 24,
    parameter int BURST_COUNT    = DEF_BURST_COUNT,
    parameter int BURST_WIDTH    = 4,
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    parameter int SPACE_WIDTH    = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_start,
    input  logic [ADDRESS_WIDTH-1:0] cfg_base,
    input  logic [LENGTH_WIDTH-1:0]  cfg_length,
    input  logic                     cfg_continuous,
    input  logic                     cfg_abort,
    input  logic [SPACE_WIDTH-1:0]   fifo_space,
    output logic                     rd_start,
    output logic [ADDRESS_WIDTH-1:0] rd_baseaddress,
    output logic [BURST_WIDTH-1:0]   rd_burstcount,
    input  logic                     rd_busy,
    input  logic                     rd_readdatavalid,
    output logic                     sts_busy,
    output logic                     sts_done,
    output logic                     sts_aborted,
    output logic                     sts_error,
    output logic [15:0]              sts_frame_count
);

    // One extra bit so a misbehaving engine that over-delivers is still
    // seen as a mismatch rather than wrapping back onto the expected count.
    localparam int BEAT_WIDTH = BURST_WIDTH + 1;
    localparam int CMP_WIDTH  = (SPACE_WIDTH > BURST_WIDTH) ? SPACE_WIDTH : BURST_WIDTH;

    state_t                   state_r;
    state_t                   state_next_s;

    logic [ADDRESS_WIDTH-1:0] base_r;
    logic [LENGTH_WIDTH-1:0]  length_r;
    logic [ADDRESS_WIDTH-1:0] addr_r;
    logic [LENGTH_WIDTH-1:0]  remaining_r;
    logic [BEAT_WIDTH-1:0]    beat_cnt_r;

    logic                     rd_start_r;
    logic [ADDRESS_WIDTH-1:0] rd_baseaddress_r;
    logic [BURST_WIDTH-1:0]   rd_burstcount_r;
    logic                     sts_busy_r;
    logic                     sts_done_r;
    logic                     sts_aborted_r;
    logic                     sts_error_r;
    logic [15:0]              sts_frame_count_r;

    logic [BURST_WIDTH-1:0]   size_s;
    logic                     space_ok_s;
    logic [BEAT_WIDTH-1:0]    beat_total_s;
    logic                     accept_start_s;
    logic                     issue_s;
    logic                     burst_end_s;
    logic                     abort_s;
    logic                     enter_finish_s;
    logic                     reload_s;

    assign rd_start        = rd_start_r;
    assign rd_baseaddress  = rd_baseaddress_r;
    assign rd_burstcount   = rd_burstcount_r;
    assign sts_busy        = sts_busy_r;
    assign sts_done        = sts_done_r;
    assign sts_aborted     = sts_aborted_r;
    assign sts_error       = sts_error_r;
    assign sts_frame_count = sts_frame_count_r;

    // Next burst size: a full burst, or the tail of the frame.
    always_comb begin
        if (remaining_r >= LENGTH_WIDTH'(BURST_COUNT)) begin
            size_s = BURST_WIDTH'(BURST_COUNT);
        end else begin
            size_s = remaining_r[BURST_WIDTH-1:0];
        end
    end

    assign space_ok_s = (CMP_WIDTH'(fifo_space) >= CMP_WIDTH'(size_s));

    // A beat arriving together with the busy fall still belongs to this burst.
    assign beat_total_s = beat_cnt_r + BEAT_WIDTH'(rd_readdatavalid);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and one-cycle event strobes for the datapath.
    always_comb begin
        state_next_s   = state_r;
        accept_start_s = 1'b0;
        issue_s        = 1'b0;
        burst_end_s    = 1'b0;
        abort_s        = 1'b0;
        enter_finish_s = 1'b0;
        reload_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_next_s   = ST_CHECK;
                    accept_start_s = 1'b1;
                end else begin
                    state_next_s   = ST_IDLE;
                end
            end
            ST_CHECK: begin
                // Frame end outranks abort; abort outranks the space test.
                if (remaining_r == {LENGTH_WIDTH{1'b0}}) begin
                    state_next_s   = ST_FINISH;
                    enter_finish_s = 1'b1;
                end else if (cfg_abort) begin
                    state_next_s   = ST_IDLE;
                    abort_s        = 1'b1;
                end else if (space_ok_s) begin
                    state_next_s   = ST_ISSUE;
                    issue_s        = 1'b1;
                end else begin
                    state_next_s   = ST_CHECK;
                end
            end
            ST_ISSUE: begin
                state_next_s = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (rd_busy) begin
                    state_next_s = ST_WAIT_DONE;
                end else begin
                    state_next_s = ST_WAIT_ACK;
                end
            end
            ST_WAIT_DONE: begin
                if (!rd_busy) begin
                    burst_end_s = 1'b1;
                    if (cfg_abort) begin
                        state_next_s = ST_IDLE;
                        abort_s      = 1'b1;
                    end else begin
                        state_next_s = ST_CHECK;
                    end
                end else begin
                    state_next_s = ST_WAIT_DONE;
                end
            end
            ST_FINISH: begin
                if (cfg_continuous) begin
                    state_next_s = ST_CHECK;
                    reload_s     = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Frame walk: captured region plus the running address and word count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_r      <= {ADDRESS_WIDTH{1'b0}};
            length_r    <= {LENGTH_WIDTH{1'b0}};
            addr_r      <= {ADDRESS_WIDTH{1'b0}};
            remaining_r <= {LENGTH_WIDTH{1'b0}};
        end else if (accept_start_s) begin
            base_r      <= cfg_base;
            length_r    <= cfg_length;
            addr_r      <= cfg_base;
            remaining_r <= cfg_length;
        end else if (reload_s) begin
            addr_r      <= base_r;
            remaining_r <= length_r;
        end else if (burst_end_s) begin
            // Address wraps silently at the top of the address space.
            addr_r      <= addr_r + (ADDRESS_WIDTH'(rd_burstcount_r) * ADDRESS_WIDTH'(BYTES_PER_WORD));
            remaining_r <= remaining_r - LENGTH_WIDTH'(rd_burstcount_r);
        end else begin
            addr_r      <= addr_r;
            remaining_r <= remaining_r;
        end
    end

    // Engine command port: start pulse plus the burst descriptor, held
    // until the next issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_start_r       <= 1'b0;
            rd_baseaddress_r <= {ADDRESS_WIDTH{1'b0}};
            rd_burstcount_r  <= {BURST_WIDTH{1'b0}};
        end else begin
            rd_start_r <= issue_s;
            if (issue_s) begin
                rd_baseaddress_r <= addr_r;
                rd_burstcount_r  <= size_s;
            end else begin
                rd_baseaddress_r <= rd_baseaddress_r;
                rd_burstcount_r  <= rd_burstcount_r;
            end
        end
    end

    // Beat counter: cleared while the start pulse is out, counts while the
    // burst drains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt_r <= {BEAT_WIDTH{1'b0}};
        end else if (state_r == ST_ISSUE) begin
            beat_cnt_r <= {BEAT_WIDTH{1'b0}};
        end else if ((state_r == ST_WAIT_DONE) && rd_readdatavalid) begin
            beat_cnt_r <= beat_total_s;
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    // Status outputs: busy level, done/abort pulses, sticky error, frame count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sts_busy_r        <= 1'b0;
            sts_done_r        <= 1'b0;
            sts_aborted_r     <= 1'b0;
            sts_error_r       <= 1'b0;
            sts_frame_count_r <= 16'd0;
        end else begin
            sts_busy_r    <= (state_next_s != ST_IDLE);
            sts_done_r    <= enter_finish_s;
            sts_aborted_r <= abort_s;
            if (accept_start_s) begin
                sts_error_r <= 1'b0;
            end else if (burst_end_s && (beat_total_s != BEAT_WIDTH'(rd_burstcount_r))) begin
                sts_error_r <= 1'b1;
            end else begin
                sts_error_r <= sts_error_r;
            end
            if (accept_start_s) begin
                sts_frame_count_r <= 16'd0;
            end else if (enter_finish_s) begin
                sts_frame_count_r <= sts_frame_count_r + 16'd1;
            end else begin
                sts_frame_count_r <= sts_frame_count_r;
            end
        end
    end

endmodule

// File: tb/tb_burst_read_sched.sv
// Self-checking bench for burst_read_sched: a table of single-shot frames
// plus hand-written sequences for stall, zero length, abort, frame looping
// and asynchronous reset. A small behavioural engine answers rd_start.
module tb_burst_read_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_start;
    logic [31:0] cfg_base;
    logic [23:0] cfg_length;
    logic        cfg_continuous;
    logic        cfg_abort;
    logic [8:0]  fifo_space;
    logic        rd_start;
    logic [31:0] rd_baseaddress;
    logic [3:0]  rd_burstcount;
    logic        rd_busy;
    logic        rd_readdatavalid;
    logic        sts_busy;
    logic        sts_done;
    logic        sts_aborted;
    logic        sts_error;
    logic [15:0] sts_frame_count;

    burst_read_sched dut (
        .clk              (clk),
        .reset            (reset),
        .cfg_start        (cfg_start),
        .cfg_base         (cfg_base),
        .cfg_length       (cfg_length),
        .cfg_continuous   (cfg_continuous),
        .cfg_abort        (cfg_abort),
        .fifo_space       (fifo_space),
        .rd_start         (rd_start),
        .rd_baseaddress   (rd_baseaddress),
        .rd_burstcount    (rd_burstcount),
        .rd_busy          (rd_busy),
        .rd_readdatavalid (rd_readdatavalid),
        .sts_busy         (sts_busy),
        .sts_done         (sts_done),
        .sts_aborted      (sts_aborted),
        .sts_error        (sts_error),
        .sts_frame_count  (sts_frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Cycle counter: during cycle k (after its rising edge) cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor log of everything the DUT emits, sampled on the falling edge.
    logic [31:0] st_addr [0:127];
    int          st_cnt  [0:127];
    int          st_cyc  [0:127];
    int          n_starts  = 0;
    int          n_done    = 0;
    int          n_abort   = 0;
    int          done_cyc  = 0;
    int          abort_cyc = 0;
    int          fall_cyc  = 0;
    logic        prev_busy = 1'b0;

    always @(negedge clk) begin
        prev_busy <= rd_busy;
        if (prev_busy && !rd_busy) fall_cyc <= cyc;
        if (rd_start) begin
            st_addr[n_starts % 128] <= rd_baseaddress;
            st_cnt[n_starts % 128]  <= int'(rd_burstcount);
            st_cyc[n_starts % 128]  <= cyc;
            n_starts <= n_starts + 1;
        end
        if (sts_done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (sts_aborted) begin
            n_abort   <= n_abort + 1;
            abort_cyc <= cyc;
        end
    end

    // Behavioural engine: busy rises the cycle after rd_start, then one beat
    // per cycle, then busy falls. short_by drops beats; merge_last delivers
    // the last beat in the same cycle busy falls.
    int short_by   = 0;
    bit merge_last = 1'b0;
    bit saw_start;
    bit eng_active;
    int eng_left;

    initial begin
        rd_busy          = 1'b0;
        rd_readdatavalid = 1'b0;
        eng_active       = 1'b0;
        eng_left         = 0;
        forever begin
            @(negedge clk);
            saw_start = rd_start;
            @(posedge clk);
            #1;
            if (reset) begin
                eng_active       = 1'b0;
                rd_busy          = 1'b0;
                rd_readdatavalid = 1'b0;
            end else if (saw_start) begin
                eng_active       = 1'b1;
                eng_left         = int'(rd_burstcount) - short_by;
                rd_busy          = 1'b1;
                rd_readdatavalid = 1'b0;
            end else if (eng_active && eng_left > 0) begin
                rd_readdatavalid = 1'b1;
                eng_left         = eng_left - 1;
                if (merge_last && eng_left == 0) begin
                    rd_busy    = 1'b0;
                    eng_active = 1'b0;
                end
            end else begin
                eng_active       = 1'b0;
                rd_busy          = 1'b0;
                rd_readdatavalid = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int start_cyc = 0;

    task automatic start_frame(input logic [31:0] base, input logic [23:0] len);
        cfg_base   = base;
        cfg_length = len;
        cfg_start  = 1'b1;
        start_cyc  = cyc;
        tick(1);
        cfg_start  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (sts_busy && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if (sts_busy) begin
            errors++;
            $display("FAIL %s timeout: sts_busy still 1 after %0d cycles", name, budget);
        end
    endtask

    task automatic wait_starts(input string name, input int target, input int budget);
        int k = 0;
        while (n_starts < target && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if (n_starts < target) begin
            errors++;
            $display("FAIL %s timeout: rd_start count %0d, required %0d", name, n_starts, target);
        end
    endtask

    task automatic wait_frames(input string name, input int target, input int budget);
        int k = 0;
        while (int'(sts_frame_count) < target && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if (int'(sts_frame_count) < target) begin
            errors++;
            $display("FAIL %s timeout: frame count %0d, required %0d", name, sts_frame_count, target);
        end
    endtask

    typedef struct {
        logic [31:0] base;
        int          length;
        int          short_by;
        bit          merge;
        int          exp_bursts;
        logic [31:0] exp_last_addr;
        int          exp_last_cnt;
        bit          exp_err;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [0:NV-1];

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s0;
        int          d0;
        int          a0;
        int          m;
        int          left;
        int          sz;
        int          prev_beats;
        logic [31:0] exp_addr;

        vecs[0] = '{32'h39000000, 20, 0, 1'b0, 3, 32'h39000040, 4, 1'b0};
        vecs[1] = '{32'h00001000,  8, 0, 1'b0, 1, 32'h00001000, 8, 1'b0};
        vecs[2] = '{32'h00000010,  1, 0, 1'b0, 1, 32'h00000010, 1, 1'b0};
        vecs[3] = '{32'hFFFFFFF0,  9, 0, 1'b0, 2, 32'h00000010, 1, 1'b0};
        vecs[4] = '{32'h00002000, 17, 0, 1'b1, 3, 32'h00002040, 1, 1'b0};
        vecs[5] = '{32'h00003000, 16, 1, 1'b0, 2, 32'h00003020, 8, 1'b1};
        vecs[6] = '{32'h00006000, 12, 0, 1'b0, 2, 32'h00006020, 4, 1'b0};

        reset          = 1'b1;
        cfg_start      = 1'b0;
        cfg_base       = 32'h0;
        cfg_length     = 24'd0;
        cfg_continuous = 1'b0;
        cfg_abort      = 1'b0;
        fifo_space     = 9'd256;

        // Reset state.
        tick(3);
        check("reset_outputs", {rd_start, rd_baseaddress, rd_burstcount, sts_busy, sts_done,
                                sts_aborted, sts_error, sts_frame_count}, 64'd0);
        reset = 1'b0;
        tick(2);

        // Table of single-shot frames.
        for (int v = 0; v < NV; v++) begin
            short_by   = vecs[v].short_by;
            merge_last = vecs[v].merge;
            s0 = n_starts;
            d0 = n_done;
            start_frame(vecs[v].base, 24'(vecs[v].length));
            wait_idle($sformatf("v%0d_idle", v), 300);
            tick(2);
            check($sformatf("v%0d_bursts", v), n_starts - s0, vecs[v].exp_bursts);
            check($sformatf("v%0d_done", v), n_done - d0, 1);
            check($sformatf("v%0d_frames", v), sts_frame_count, 1);
            check($sformatf("v%0d_error", v), sts_error, vecs[v].exp_err);
            check($sformatf("v%0d_last_addr", v), st_addr[(n_starts - 1) % 128], vecs[v].exp_last_addr);
            check($sformatf("v%0d_last_cnt", v), st_cnt[(n_starts - 1) % 128], vecs[v].exp_last_cnt);
            check($sformatf("v%0d_latency", v), st_cyc[s0 % 128] - start_cyc, 2);
            left       = vecs[v].length;
            exp_addr   = vecs[v].base;
            prev_beats = 0;
            for (int b = 0; b < vecs[v].exp_bursts; b++) begin
                sz = (left > 8) ? 8 : left;
                check($sformatf("v%0d_b%0d_addr", v, b), st_addr[(s0 + b) % 128], exp_addr);
                check($sformatf("v%0d_b%0d_cnt", v, b), st_cnt[(s0 + b) % 128], sz);
                if (b > 0) begin
                    check($sformatf("v%0d_b%0d_gap", v, b),
                          st_cyc[(s0 + b) % 128] - st_cyc[(s0 + b - 1) % 128],
                          prev_beats + 4 - int'(merge_last));
                end
                prev_beats = sz - short_by;
                exp_addr   = exp_addr + 32'(sz * 4);
                left       = left - sz;
            end
            tick(4);
            check($sformatf("v%0d_error_held", v), sts_error, vecs[v].exp_err);
        end
        short_by   = 0;
        merge_last = 1'b0;

        // Zero-length frame: done two cycles after start, nothing issued.
        s0 = n_starts;
        d0 = n_done;
        start_frame(32'h00007000, 24'd0);
        wait_idle("zero_idle", 20);
        tick(2);
        check("zero_done", n_done - d0, 1);
        check("zero_done_cycle", done_cyc - start_cyc, 2);
        check("zero_no_start", n_starts - s0, 0);
        check("zero_frames", sts_frame_count, 1);

        // FIFO-space stall: 5 free words cannot take an 8-word burst.
        fifo_space = 9'd5;
        s0 = n_starts;
        d0 = n_done;
        start_frame(32'h00008000, 24'd8);
        tick(10);
        check("stall_no_start", n_starts - s0, 0);
        check("stall_busy", sts_busy, 1'b1);
        fifo_space = 9'd8;
        m = cyc;
        wait_starts("stall_release", s0 + 1, 10);
        check("stall_release_cycle", st_cyc[s0 % 128] - m, 1);
        fifo_space = 9'd256;
        wait_idle("stall_idle", 50);
        tick(2);
        check("stall_done", n_done - d0, 1);

        // Abort in the middle of the first burst.
        s0 = n_starts;
        d0 = n_done;
        a0 = n_abort;
        start_frame(32'h00009000, 24'd20);
        wait_starts("abort_first", s0 + 1, 20);
        tick(3);
        cfg_abort = 1'b1;
        wait_idle("abort_idle", 50);
        tick(2);
        cfg_abort = 1'b0;
        check("abort_starts", n_starts - s0, 1);
        check("abort_pulse", n_abort - a0, 1);
        check("abort_after_fall", abort_cyc - fall_cyc, 1);
        check("abort_no_done", n_done - d0, 0);
        check("abort_error", sts_error, 1'b0);
        check("abort_busy", sts_busy, 1'b0);
        check("abort_frames", sts_frame_count, 0);

        // Continuous mode: stop after the third frame.
        s0 = n_starts;
        d0 = n_done;
        cfg_continuous = 1'b1;
        start_frame(32'h0000A000, 24'd16);
        wait_frames("cont_two", 2, 200);
        m = n_starts;
        wait_starts("cont_third", m + 1, 20);
        cfg_continuous = 1'b0;
        wait_idle("cont_idle", 100);
        tick(2);
        check("cont_starts", n_starts - s0, 6);
        for (int b = 0; b < 6; b++) begin
            check($sformatf("cont_b%0d_addr", b), st_addr[(s0 + b) % 128], 32'h0000A000 + 32'((b % 2) * 32));
            check($sformatf("cont_b%0d_cnt", b), st_cnt[(s0 + b) % 128], 8);
        end
        check("cont_frames", sts_frame_count, 3);
        check("cont_done", n_done - d0, 3);

        // Asynchronous reset while a burst drains.
        s0 = n_starts;
        start_frame(32'h0000B000, 24'd16);
        wait_starts("rst_first", s0 + 1, 20);
        tick(3);
        reset = 1'b1;
        #1;
        check("rst_async_outputs", {rd_start, rd_baseaddress, rd_burstcount, sts_busy, sts_done,
                                    sts_aborted, sts_error, sts_frame_count}, 64'd0);
        tick(2);
        reset = 1'b0;
        tick(3);
        check("rst_after_release", {rd_start, sts_busy, sts_frame_count}, 64'd0);

        // Recovery after reset.
        d0 = n_done;
        start_frame(32'h0000C000, 24'd8);
        wait_idle("recover_idle", 50);
        tick(2);
        check("recover_done", n_done - d0, 1);
        check("recover_frames", sts_frame_count, 1);
        check("recover_addr", st_addr[(n_starts - 1) % 128], 32'h0000C000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
